tag_sequencer: RTL

TAG_SEQUENCER -- requirements
Module: tag_sequencer

---
 rtl/tag_sequencer_pkg.sv | 22 ++
 rtl/tag_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/tag_sequencer_pkg.sv
// Shared definitions for the tag sequencer and its datapath wrapper.
// Holds the state encoding, default sizes and the accumulator modulus.
package tag_sequencer_pkg;

    // 238-bit challenge consumed 14 bits per step.
    localparam int TS_NSTEP = 17;

    // Accumulator element width and its modulus.
    localparam int TS_W     = 7;
    localparam int TS_MOD   = 127;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD0,
        S_RUN0,
        S_OUT0,
        S_LOAD1,
        S_RUN1,
        S_OUT1
    } ts_state_e;

endpackage

// File: rtl/tag_sequencer.sv
// Tag sequencer: drives load/step strobes of the inner-product datapath
// for one (b/x) or two (b/x then a/y) passes and presents each tag.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, dual        request a tag; dual=1 runs the a/y pass as well
//   ldb lda ldx ldy    operand load strobes
//   lde, innerprod     accumulator init and step strobes
//   u_in               datapath accumulator value
//   tag_data/idx/valid tag output with valid/ready handshake
//   tag_ready          consumer accepts the tag
//   busy               high whenever not idle
module tag_sequencer
    import tag_sequencer_pkg::*;
#(
    parameter int NSTEP = TS_NSTEP,
    parameter int W     = TS_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         dual,
    output logic         ldb,
    output logic         lda,
    output logic         ldx,
    output logic         ldy,
    output logic         lde,
    output logic         innerprod,
    input  logic [W-1:0] u_in,
    output logic [W-1:0] tag_data,
    output logic         tag_idx,
    output logic         tag_valid,
    input  logic         tag_ready,
    output logic         busy
);

    localparam int CW = $clog2(NSTEP + 1);
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    ts_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dual_q, dual_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dual_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dual_q  <= dual_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dual_d    = dual_q;
        ldb       = 1'b0;
        lda       = 1'b0;
        ldx       = 1'b0;
        ldy       = 1'b0;
        lde       = 1'b0;
        innerprod = 1'b0;
        tag_data  = '0;
        tag_idx   = 1'b0;
        tag_valid = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD0;
                    dual_d  = dual;
                end
            end
            S_LOAD0: begin
                lde     = 1'b1;
                ldb     = 1'b1;
                ldx     = 1'b1;
                cnt_d   = '0;
                state_d = S_RUN0;
            end
            S_RUN0: begin
                innerprod = 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_OUT0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUT0: begin
                tag_valid = 1'b1;
                tag_data  = u_in;
                if (tag_ready) begin
                    state_d = dual_q ? S_LOAD1 : S_IDLE;
                end
            end
            // No lde here: the accumulator keeps tag0 and chains the a/y pass.
            S_LOAD1: begin
                lda     = 1'b1;
                ldy     = 1'b1;
                cnt_d   = '0;
                state_d = S_RUN1;
            end
            S_RUN1: begin
                innerprod = 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_OUT1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUT1: begin
                tag_valid = 1'b1;
                tag_idx   = 1'b1;
                tag_data  = u_in;
                if (tag_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule
